fir_result_capture: RTL and testbench
=====================================

// Module: fir_result_capture
// PURPOSE
//  Sink-side partner of the HLS FIR filter IP. Frame-based capture of filter results
//  (output_r qualified by result_valid) into a FIFO. The FIFO is drained over a
//  valid/ready stream that tags the final sample of each frame.
//  Sits between the FIR core and the downstream logger/DMA.
// PARAMETERS
//  DATA_W  32  width of a FIR result sample
//  ADDR_W  4   FIFO address width; depth = 2**ADDR_W entries
//  CNT_W   16  width of frame length / sample counter
// PORTS
//  ap_clk      in   1         clock; all logic on rising edge
//  ap_rst_n    in   1         async active-low reset
//  start       in   1         pulse: arm capture of one frame (IDLE only)
//  abort       in   1         sync abort: flush FIFO, return to IDLE
//  frame_len   in   CNT_W     samples per frame, sampled on accepted start
//  fir_out     in   DATA_W    FIR result (connects to output_r)
//  fir_valid   in   1         FIR result strobe (connects to result_valid)
//  m_data      out  DATA_W    stream data (FIFO head)
//  m_last      out  1         high with the final sample of the frame
//  m_valid     out  1         stream valid
//  m_ready     in   1         stream ready; transfer when m_valid & m_ready
//  busy        out  1         high in CAPTURE or DRAIN
//  done        out  1         one-cycle pulse on frame fully drained
//  overflow    out  1         sticky: a sample was dropped on a full FIFO
//  clr_ovf     in   1         sync clear of overflow
//  level       out  ADDR_W+1  FIFO occupancy
// BEHAVIOUR
//  Reset: state=IDLE, FIFO empty, count=0; m_valid=0, m_last=0, m_data=0,
//  busy=0, done=0, overflow=0, level=0.
//  FSM IDLE -> CAPTURE: on start with frame_len!=0. Latches frame_len; count=0.
//    start with frame_len==0 is ignored. start outside IDLE is ignored.
//  CAPTURE: on fir_valid with FIFO not full, push {last,fir_out} and increment count.
//    last = (count==frame_len-1). On the push with last=1, go to DRAIN.
//    fir_valid outside CAPTURE is ignored and does not set overflow.
//  Full FIFO: fir_valid while full drops the sample and sets overflow.
//    The dropped sample is not counted, so every frame emits exactly frame_len words.
//    A full FIFO refuses a push even if a pop happens in the same cycle.
//    full is derived from the registered level.
//  DRAIN: go to DONE once the FIFO is empty and the last-tagged word has transferred.
//  DONE: done=1 for one cycle, then IDLE.
//  Output stream: first-word-fall-through. m_valid = (level!=0); m_data/m_last show the head.
//    A sample pushed at edge k is visible on m_data in cycle k+1 (1-cycle latency).
//    m_data/m_last hold stable while m_valid & !m_ready.
//  Simultaneous push and pop (not full): level unchanged and both take effect.
//  Pointers wrap modulo 2**ADDR_W. level ranges 0..2**ADDR_W.
//  abort (any state): next cycle state=IDLE, FIFO empty, count=0, no done pulse.
//    overflow is preserved. abort has priority over start and fir_valid in the same cycle.
//  clr_ovf: clears overflow at the next edge. A drop in the same cycle wins (overflow stays 1).
//  Counter: CNT_W bits unsigned. frame_len=2**CNT_W-1 is the maximum frame.
// TESTING
//  1 Reset mid-CAPTURE with 3 words queued -> all outputs 0, level=0, IDLE; first edge after
//    release accepts nothing.
//  2 frame_len=5, fir_valid every cycle 10,20,..,70, m_ready=1 -> stream 10..50, m_last only
//    on 50, samples 60/70 ignored, done pulses once, busy falls with done.
//  3 frame_len=20, fir_valid every cycle, m_ready=0 -> level stops at 16, overflow=1,
//    4 samples dropped; m_ready=1 -> still 20 words out, m_last on 20th.
//  4 Full FIFO, fir_valid & m_ready same cycle -> pop happens, push refused, level=15,
//    overflow=1.
//  5 abort in DRAIN with level=6 -> next cycle level=0, m_valid=0, no done,
//    overflow unchanged; new start accepted.
//  6 start with frame_len=0 -> stays IDLE, busy=0, no done. clr_ovf with overflow=1 and
//    no drop -> overflow=0.

Source files
------------

// File: rtl/fir_result_capture.sv
// fir_result_capture: frame-based capture of FIR results into a FWFT FIFO,
// drained over a valid/ready stream with the final sample of each frame tagged.
module fir_result_capture #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4,
    parameter int CNT_W  = 16
) (
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [CNT_W-1:0]  frame_len,
    input  logic [DATA_W-1:0] fir_out,
    input  logic              fir_valid,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    input  logic              clr_ovf,
    output logic [ADDR_W:0]   level
);
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN, DONE} state_t;

    state_t            state, state_nx;
    logic [DATA_W:0]   mem [DEPTH];
    logic [DATA_W:0]   head;
    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count, len_q;
    logic              full, accept, push, drop, pop, last;

    assign full    = level == (ADDR_W + 1)'(DEPTH);
    assign accept  = state == IDLE && start && frame_len != '0 && !abort;
    assign push    = state == CAPTURE && fir_valid && !full && !abort;
    assign drop    = state == CAPTURE && fir_valid && full && !abort;
    assign pop     = m_valid && m_ready && !abort;
    assign last    = count == len_q - CNT_W'(1);
    assign head    = mem[rd_ptr];
    assign m_valid = level != '0;
    // Gate the head so the stream reads zero whenever the FIFO is empty.
    assign m_data  = m_valid ? head[DATA_W-1:0] : '0;
    assign m_last  = m_valid && head[DATA_W];
    assign busy    = state == CAPTURE || state == DRAIN;
    assign done    = state == DONE;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = accept ? CAPTURE : IDLE;
            CAPTURE: state_nx = (push && last) ? DRAIN : CAPTURE;
            DRAIN:   state_nx = (pop && m_last) ? DONE : DRAIN;
            default: state_nx = IDLE;
        endcase
        if (abort) state_nx = IDLE;
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state    <= IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            count    <= '0;
            len_q    <= '0;
            overflow <= 1'b0;
        end else begin
            state <= state_nx;
            if (abort) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                level  <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + ADDR_W'(1);
                if (pop) rd_ptr <= rd_ptr + ADDR_W'(1);
                level <= level + (ADDR_W + 1)'(push) - (ADDR_W + 1)'(pop);
                if (accept) begin
                    len_q <= frame_len;
                    count <= '0;
                end else if (push) begin
                    count <= count + CNT_W'(1);
                end
            end
            if (drop) overflow <= 1'b1;
            else if (clr_ovf) overflow <= 1'b0;
        end
    end

    always_ff @(posedge ap_clk) begin
        if (push) mem[wr_ptr] <= {last, fir_out};
    end
endmodule

// File: tb/tb_fir_result_capture.sv
// tb_fir_result_capture: directed vector table plus hand-written corner sequences.
module tb_fir_result_capture;
    logic        ap_clk, ap_rst_n, start, abort, fir_valid, m_ready, clr_ovf;
    logic [15:0] frame_len;
    logic [31:0] fir_out, m_data;
    logic        m_last, m_valid, busy, done, overflow;
    logic [4:0]  level;

    fir_result_capture dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .start(start), .abort(abort),
        .frame_len(frame_len), .fir_out(fir_out), .fir_valid(fir_valid),
        .m_data(m_data), .m_last(m_last), .m_valid(m_valid), .m_ready(m_ready),
        .busy(busy), .done(done), .overflow(overflow), .clr_ovf(clr_ovf), .level(level)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    typedef struct {
        logic        start;
        logic [15:0] len;
        logic        fv;
        logic [31:0] d;
        logic        rdy;
        logic        ev;
        logic [31:0] ed;
        logic        el;
        logic        eb;
        logic        edn;
        logic [4:0]  elv;
    } vec_t;

    int n_cmp = 0;
    int n_err = 0;
    int xfer_n = 0;
    int done_n = 0;
    logic [32:0] xfer_log [256];

    always @(negedge ap_clk) begin
        if (ap_rst_n && m_valid && m_ready) begin
            xfer_log[xfer_n[7:0]] = {m_last, m_data};
            xfer_n++;
        end
        if (done) done_n++;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge ap_clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    vec_t tv [9];
    int x0, d0;

    initial begin
        // inputs: start, len, fv, data, rdy; expected: valid, data, last, busy, done, level
        tv[0] = '{1'b1, 16'd5, 1'b0, 32'd0,  1'b1, 1'b0, 32'd0,  1'b0, 1'b1, 1'b0, 5'd0};
        tv[1] = '{1'b0, 16'd0, 1'b1, 32'd10, 1'b1, 1'b1, 32'd10, 1'b0, 1'b1, 1'b0, 5'd1};
        tv[2] = '{1'b0, 16'd0, 1'b1, 32'd20, 1'b1, 1'b1, 32'd20, 1'b0, 1'b1, 1'b0, 5'd1};
        tv[3] = '{1'b0, 16'd0, 1'b1, 32'd30, 1'b1, 1'b1, 32'd30, 1'b0, 1'b1, 1'b0, 5'd1};
        tv[4] = '{1'b0, 16'd0, 1'b1, 32'd40, 1'b1, 1'b1, 32'd40, 1'b0, 1'b1, 1'b0, 5'd1};
        tv[5] = '{1'b0, 16'd0, 1'b1, 32'd50, 1'b1, 1'b1, 32'd50, 1'b1, 1'b1, 1'b0, 5'd1};
        tv[6] = '{1'b0, 16'd0, 1'b1, 32'd60, 1'b1, 1'b0, 32'd0,  1'b0, 1'b0, 1'b1, 5'd0};
        tv[7] = '{1'b0, 16'd0, 1'b1, 32'd70, 1'b1, 1'b0, 32'd0,  1'b0, 1'b0, 1'b0, 5'd0};
        tv[8] = '{1'b0, 16'd0, 1'b0, 32'd0,  1'b1, 1'b0, 32'd0,  1'b0, 1'b0, 1'b0, 5'd0};

        ap_rst_n = 1'b0; start = 0; abort = 0; fir_valid = 0; m_ready = 0; clr_ovf = 0;
        frame_len = 0; fir_out = 0;
        tick; tick;
        chk("rst_level", level, 0);
        chk("rst_valid", m_valid, 0);
        chk("rst_data", m_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ovf", overflow, 0);
        @(negedge ap_clk) ap_rst_n = 1'b1;
        tick;

        // 1: reset mid-capture with 3 words queued
        start = 1; frame_len = 10; tick; start = 0;
        for (int i = 1; i <= 3; i++) begin fir_valid = 1; fir_out = i; tick; end
        chk("t1_level3", level, 3);
        chk("t1_busy", busy, 1);
        #2 ap_rst_n = 1'b0;
        #1;
        chk("t1_rst_level", level, 0);
        chk("t1_rst_valid", m_valid, 0);
        chk("t1_rst_last", m_last, 0);
        chk("t1_rst_data", m_data, 0);
        chk("t1_rst_busy", busy, 0);
        chk("t1_rst_done", done, 0);
        @(negedge ap_clk) ap_rst_n = 1'b1;
        tick;
        chk("t1_post_level", level, 0);
        chk("t1_post_busy", busy, 0);
        fir_valid = 0; tick;

        // 2: table-driven frame of 5
        d0 = done_n;
        for (int i = 0; i < 9; i++) begin
            start = tv[i].start; frame_len = tv[i].len; fir_valid = tv[i].fv;
            fir_out = tv[i].d; m_ready = tv[i].rdy;
            tick;
            chk($sformatf("t2_valid[%0d]", i), m_valid, tv[i].ev);
            if (tv[i].ev) begin
                chk($sformatf("t2_data[%0d]", i), m_data, tv[i].ed);
                chk($sformatf("t2_last[%0d]", i), m_last, tv[i].el);
            end
            chk($sformatf("t2_busy[%0d]", i), busy, tv[i].eb);
            chk($sformatf("t2_done[%0d]", i), done, tv[i].edn);
            chk($sformatf("t2_level[%0d]", i), level, tv[i].elv);
        end
        chk("t2_done_once", done_n - d0, 1);
        start = 0; fir_valid = 0;

        // 3/4: frame of 20 into a 16-deep FIFO with the sink stalled
        x0 = xfer_n; d0 = done_n;
        m_ready = 0; start = 1; frame_len = 20; tick; start = 0;
        for (int i = 1; i <= 20; i++) begin fir_valid = 1; fir_out = i; tick; end
        chk("t3_level16", level, 16);
        chk("t3_ovf", overflow, 1);
        chk("t3_busy", busy, 1);
        m_ready = 1; fir_out = 100; tick;
        chk("t4_level15", level, 15);
        chk("t4_ovf", overflow, 1);
        chk("t4_head", m_data, 2);
        for (int i = 17; i <= 20; i++) begin fir_out = i; tick; end
        chk("t3_level_steady", level, 15);
        fir_valid = 0;
        for (int i = 0; i < 40 && done_n == d0; i++) tick;
        tick; tick;
        chk("t3_done_once", done_n - d0, 1);
        chk("t3_busy_end", busy, 0);
        chk("t3_words", xfer_n - x0, 20);
        for (int k = 0; k < 20; k++) begin
            chk($sformatf("t3_word[%0d]", k), xfer_log[(x0 + k) % 256][31:0], k + 1);
            chk($sformatf("t3_lastbit[%0d]", k), xfer_log[(x0 + k) % 256][32], k == 19);
        end

        // 5: abort in DRAIN with 6 words queued
        d0 = done_n;
        m_ready = 0; start = 1; frame_len = 6; tick; start = 0;
        for (int i = 1; i <= 6; i++) begin fir_valid = 1; fir_out = 32'h50 + i; tick; end
        fir_valid = 0;
        chk("t5_level6", level, 6);
        chk("t5_busy_drain", busy, 1);
        abort = 1; tick; abort = 0;
        chk("t5_level0", level, 0);
        chk("t5_valid0", m_valid, 0);
        chk("t5_busy0", busy, 0);
        chk("t5_ovf_kept", overflow, 1);
        tick;
        chk("t5_no_done", done_n - d0, 0);
        start = 1; frame_len = 2; tick; start = 0;
        chk("t5_restart", busy, 1);
        abort = 1; tick; abort = 0;
        chk("t5_abort2", busy, 0);

        // 6: zero-length start and overflow clear
        d0 = done_n;
        start = 1; frame_len = 0; tick; start = 0;
        chk("t6_busy0", busy, 0);
        tick;
        chk("t6_busy0b", busy, 0);
        chk("t6_no_done", done_n - d0, 0);
        clr_ovf = 1; tick; clr_ovf = 0;
        chk("t6_ovf_clr", overflow, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
